// File: rtl/seq_pattern_tx_if.sv
// Handshake bundle for seq_pattern_tx: burst request fields in, serial stream and status out.
interface seq_pattern_tx_if #(
    parameter int W = 4
);
    logic         start;
    logic [W-1:0] pattern;
    logic [7:0]   reps;
    logic [3:0]   gap;
    logic         abort;
    logic         x;
    logic         x_valid;
    logic         busy;
    logic         done;

    modport master (
        output start, pattern, reps, gap, abort,
        input  x, x_valid, busy, done
    );

    modport slave (
        input  start, pattern, reps, gap, abort,
        output x, x_valid, busy, done
    );
endinterface

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: W-bit pattern MSB-first, repeated reps times with gap idle bits between.
// Optional feature macro SEQ_TX_PARITY_EN appends an even-parity bit to every repetition.
module seq_pattern_tx #(
    parameter int           W           = 4,
    parameter logic [W-1:0] DEF_PATTERN = W'(4'b1010)
) (
    input  logic            clk,
    input  logic            rst_n,
    seq_pattern_tx_if.slave bus
);

`ifdef SEQ_TX_PARITY_EN
    localparam int REP_BITS = W + 1;
`else
    localparam int REP_BITS = W;
`endif
    localparam int            BW       = $clog2(W + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(REP_BITS - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] GAP   = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]    state;
    logic [W-1:0]  pat_q;
    logic [W-1:0]  shift_q;
    logic [7:0]    rep_cnt;
    logic [BW-1:0] bit_cnt;
    logic [3:0]    gap_q;
    logic [3:0]    gap_cnt;
    logic          bit_out;

    // NOTE: every register here is state, so all are assigned with <= and all get an async reset value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pat_q   <= DEF_PATTERN;
            shift_q <= '0;
            rep_cnt <= '0;
            bit_cnt <= '0;
            gap_q   <= '0;
            gap_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // abort is deliberately not looked at here: start always wins in IDLE
                    if (bus.start) begin
                        pat_q   <= bus.pattern;
                        shift_q <= bus.pattern;
                        rep_cnt <= bus.reps;
                        gap_q   <= bus.gap;
                        bit_cnt <= '0;
                        state   <= (bus.reps == 8'd0) ? DONE : SHIFT;
                    end
                end
                SHIFT: begin
                    if (bus.abort) begin
                        state <= IDLE;
                    end else if (bit_cnt == LAST_BIT) begin
                        // End of a repetition: shift register is reloaded now so GAP can hand straight back
                        bit_cnt <= '0;
                        shift_q <= pat_q;
                        rep_cnt <= rep_cnt - 8'd1;
                        if (rep_cnt == 8'd1) begin
                            state <= DONE;
                        end else if (gap_q != 4'd0) begin
                            gap_cnt <= gap_q;
                            state   <= GAP;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + BW'(1);
                        shift_q <= {shift_q[W-2:0], 1'b0};
                    end
                end
                GAP: begin
                    if (bus.abort) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 4'd1;
                        if (gap_cnt == 4'd1) state <= SHIFT;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SEQ_TX_PARITY_EN
    assign bit_out = (bit_cnt == LAST_BIT) ? ^pat_q : shift_q[W-1];
`else
    assign bit_out = shift_q[W-1];
`endif

    // Outputs decode registered state only, so they clear the instant reset asserts
    assign bus.x_valid = (state == SHIFT);
    assign bus.x       = bus.x_valid & bit_out;
    assign bus.busy    = (state != IDLE);
    assign bus.done    = (state == DONE);

endmodule

// File: doc/seq_pattern_tx.md
Name: seq_pattern_tx

Overview:
Serial pattern transmitter: emits a programmable W-bit pattern MSB-first on a single-bit stream, repeated N times with optional idle gaps between repetitions. It is the stimulus and source side of the FSM sequence-detector family. Its x output drives the x input of a 1010 Mealy detector directly, in both the overlapping and non-overlapping variants. It sits alongside the detectors in the FSM library and serves as both a link source and the detectors' self-checking driver.

Parameters:
W, 4, pattern width in bits (2..16)
DEF_PATTERN, 4'b1010, pattern loaded at reset into the pattern register

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request a burst; sampled only in IDLE
pattern  input  W  pattern captured on accepted start
reps  input  8  repetition count captured on accepted start
gap  input  4  idle bits inserted between repetitions, captured on accepted start
abort  input  1  synchronous cancel of the current burst
x  output  1  serial data out; 0 when not valid
x_valid  output  1  x carries a pattern bit this cycle
busy  output  1  burst in progress
done  output  1  one-cycle pulse at normal burst completion

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - state=IDLE
  - x=0, x_valid=0, busy=0, done=0
  - pattern register=DEF_PATTERN
  - rep counter=0, bit counter=0, gap counter=0
- FSM states: IDLE, SHIFT, GAP, DONE.
- IDLE:
  - start=1 at edge k: capture pattern, reps and gap, load the shift register, go to SHIFT.
  - If reps==0, go to DONE instead; no bits are emitted.
- SHIFT:
  - x = shift register MSB, x_valid=1, for W consecutive cycles. The first bit appears in cycle k+1.
  - After the last bit:
    - Remaining reps>0 and gap>0: go to GAP.
    - Remaining reps>0 and gap==0: reload the shift register and stay in SHIFT. This gives back-to-back repetitions with no bubble.
    - Last repetition done: go to DONE.
- GAP: x=0, x_valid=0 for exactly gap cycles. Then reload the shift register and go to SHIFT.
- DONE: done=1 for one cycle, then IDLE.
- busy:
  - 1 in every cycle from k+1 through the DONE cycle inclusive.
  - 0 in IDLE.
- Burst latency:
  - Last data bit is in cycle k + reps·W + (reps−1)·gap.
  - done is in the cycle after the last data bit.
- Counters:
  - Repetition counter is 8 bits, decremented after each repetition; no wrap.
  - Bit counter is ceil(log2(W+1)) bits; the gap counter is 4 bits.
- start outside IDLE is ignored. Captured values do not change mid-burst.
- abort=1 in any non-IDLE state at edge m:
  - State goes to IDLE at edge m; x=0 and x_valid=0 from cycle m+1.
  - No done pulse.
  - abort in IDLE has no effect.
- abort and start both high in IDLE: start wins, the burst begins.
- Reset mid-burst: outputs go to reset values immediately; no done pulse.

Optional Feature:
SEQ_TX_PARITY_EN
- Defined:
  - After the W pattern bits of each repetition, one extra bit is emitted with x_valid=1. It is even parity (XOR) of the pattern.
  - Each repetition is W+1 bits, and all latency formulas use W+1 in place of W.
  - Gap insertion happens after the parity bit.
- Undefined: there is no parity bit, and the behaviour is as above.

Test Plan:
- Back-to-back burst:
  - Stimulus: pattern=1010, reps=3, gap=0, start at edge k.
  - Response: x_valid high in cycles k+1..k+12 with x=101010101010, done in k+13, busy low from k+14.
  - With an overlapping 1010 detector on x, z pulses 5 times; with a non-overlapping detector, 3 times.
- Gapped burst:
  - Stimulus: pattern=1010, reps=2, gap=3.
  - Response: 1010 in k+1..k+4, x=0 with x_valid=0 in k+5..k+7, 1010 in k+8..k+11, done in k+12.
- Zero reps:
  - Stimulus: reps=0, start at edge k.
  - Response: no x_valid, done=1 in k+1, busy=1 only in k+1.
- Abort:
  - Stimulus: pattern=1100, reps=4, gap=0, abort at edge k+6.
  - Response: x_valid=0 from k+7, done never asserts, busy=0 from k+7.
  - A new start at k+8 is accepted and emits a full burst.
- Ignored start and mid-burst reset:
  - Stimulus: start pulse during SHIFT.
  - Response: burst is unchanged and busy stays high.
  - Stimulus: rst_n low mid-burst.
  - Response: x, x_valid, busy, done all 0 immediately; pattern register returns to 1010.
- Parity (SEQ_TX_PARITY_EN defined):
  - Stimulus: pattern=1011, reps=2, gap=0.
  - Response: x=1011110111 over k+1..k+10 (parity 1), done in k+11.
